// File: rtl/beep_sequencer.sv
// Buzzer sequencer: plays N chirps or one long tone per accepted request.
// Optional `BEEP_ABORT_EN adds an abort input that returns the block to idle.
module beep_sequencer #(
   parameter int TONE_DIV      = 12500,
   parameter int CHIRP_ON_CYC  = 2500000,
   parameter int CHIRP_OFF_CYC = 2500000,
   parameter int LONG_ON_CYC   = 12500000
) (
   input  logic       ext_clk_25m,
   input  logic       ext_rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_long,
   input  logic [2:0] req_count,
   input  logic       mute,
`ifdef BEEP_ABORT_EN
   input  logic       abort,
`endif
   output logic       busy,
   output logic       beep
);

   localparam logic [15:0] TONE_LAST   = 16'(TONE_DIV - 1);
   localparam logic [23:0] CHIRP_ON_LD = 24'(CHIRP_ON_CYC - 1);
   localparam logic [23:0] CHIRP_OFF_LD = 24'(CHIRP_OFF_CYC - 1);
   localparam logic [23:0] LONG_ON_LD  = 24'(LONG_ON_CYC - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

   state_t      state_q, state_d;
   logic [23:0] timer_q, timer_d;
   logic [15:0] tone_cnt_q, tone_cnt_d;
   logic        tone_phase_q, tone_phase_d;
   logic [2:0]  remaining_q, remaining_d;
   logic        beep_q, beep_d;
   logic        abort_w;
   logic        accept_w;

`ifdef BEEP_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // Abort wins over a simultaneous request.
   assign accept_w = req_valid & (state_q == ST_IDLE) & ~abort_w;

   always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         tone_cnt_q   <= '0;
         tone_phase_q <= 1'b0;
         remaining_q  <= '0;
         beep_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         tone_cnt_q   <= tone_cnt_d;
         tone_phase_q <= tone_phase_d;
         remaining_q  <= remaining_d;
         beep_q       <= beep_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      tone_cnt_d   = '0;
      tone_phase_d = 1'b0;
      remaining_d  = remaining_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_w) begin
               state_d      = ST_ON;
               timer_d      = req_long ? LONG_ON_LD : CHIRP_ON_LD;
               remaining_d  = (req_long || req_count == 3'd0) ? 3'd0 : req_count - 3'd1;
               tone_phase_d = 1'b1;
            end
         end
         ST_ON: begin
            if (timer_q == 24'd0) begin
               state_d = ST_OFF;
               timer_d = CHIRP_OFF_LD;
            end else begin
               timer_d = timer_q - 24'd1;
               if (tone_cnt_q == TONE_LAST) begin
                  tone_cnt_d   = '0;
                  tone_phase_d = ~tone_phase_q;
               end else begin
                  tone_cnt_d   = tone_cnt_q + 16'd1;
                  tone_phase_d = tone_phase_q;
               end
            end
         end
         ST_OFF: begin
            if (timer_q == 24'd0) begin
               if (remaining_q != 3'd0) begin
                  state_d      = ST_ON;
                  timer_d      = CHIRP_ON_LD;
                  remaining_d  = remaining_q - 3'd1;
                  tone_phase_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               timer_d = timer_q - 24'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
      if (abort_w && state_q != ST_IDLE) begin
         state_d      = ST_IDLE;
         timer_d      = '0;
         remaining_d  = '0;
         tone_cnt_d   = '0;
         tone_phase_d = 1'b0;
      end
   end

   // Registering the next phase makes beep rise right after acceptance.
   assign beep_d = tone_phase_d & ~mute;

   always_comb begin
      busy      = (state_q != ST_IDLE);
      req_ready = (state_q == ST_IDLE);
   end

   assign beep = beep_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// Self-checking bench for beep_sequencer with a cycle-level reference of the beep cadence.
`timescale 1ns/1ps
module tb_beep_sequencer;

   localparam int TONE_DIV  = 4;
   localparam int CHIRP_ON  = 20;
   localparam int CHIRP_OFF = 10;
   localparam int LONG_ON   = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_long = 1'b0;
   logic [2:0] req_count = 3'd0;
   logic       mute = 1'b0;
   logic       busy;
   logic       beep;
`ifdef BEEP_ABORT_EN
   logic       abort = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int mute_tab [0:255];

   always #20 clk = ~clk;

   beep_sequencer #(
      .TONE_DIV     (TONE_DIV),
      .CHIRP_ON_CYC (CHIRP_ON),
      .CHIRP_OFF_CYC(CHIRP_OFF),
      .LONG_ON_CYC  (LONG_ON)
   ) dut (
      .ext_clk_25m(clk),
      .ext_rst_n  (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_long   (req_long),
      .req_count  (req_count),
      .mute       (mute),
`ifdef BEEP_ABORT_EN
      .abort      (abort),
`endif
      .busy       (busy),
      .beep       (beep)
   );

   task automatic chk(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
      end
   endtask

   // Tone level k cycles after acceptance: square wave of half-period TONE_DIV during the on-part of each period.
   function automatic logic exp_tone(input logic lng, input int k);
      int on_len;
      int p;
      on_len = lng ? LONG_ON : CHIRP_ON;
      p = k % (on_len + CHIRP_OFF);
      return (p < on_len) && (((p / TONE_DIV) % 2) == 0);
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, " busy"}, busy, 1'b0);
      chk({tag, " req_ready"}, req_ready, 1'b1);
      chk({tag, " beep"}, beep, 1'b0);
   endtask

   // One request; mute_mode 0 none, 1 mute the second chirp period, 2 random mute.
   task automatic run_req(input logic lng, input logic [2:0] cnt, input int mute_mode,
                          input int rst_at, input int abort_at, input bit keep_valid);
      int  n;
      int  total;
      logic expv;
      n = (lng || cnt == 3'd0) ? 1 : int'(cnt);
      total = lng ? (LONG_ON + CHIRP_OFF) : n * (CHIRP_ON + CHIRP_OFF);
      for (int i = 0; i <= total; i++)
         mute_tab[i] = (mute_mode == 1) ? int'(i >= 30 && i < 60) :
                       (mute_mode == 2) ? int'($urandom_range(0, 1)) : 0;
      $display("request long=%0b count=%0d mute_mode=%0d expect %0d busy cycles", lng, cnt, mute_mode, total);
      req_long  = lng;
      req_count = cnt;
      req_valid = 1'b1;
      mute      = 1'(mute_tab[0]);
      @(posedge clk); #1;
      if (!keep_valid) req_valid = 1'b0;
      for (int k = 0; k < total; k++) begin
         expv = exp_tone(lng, k) && (mute_tab[k] == 0);
         chk($sformatf("busy k=%0d", k), busy, 1'b1);
         chk($sformatf("req_ready k=%0d", k), req_ready, 1'b0);
         chk($sformatf("beep k=%0d", k), beep, expv);
         req_long  = 1'($urandom);
         req_count = 3'($urandom);
         if (k == rst_at) begin
            req_valid = 1'b0;
            #5 rst_n = 1'b0;
            #1 chk_idle($sformatf("async reset k=%0d", k));
            @(posedge clk); @(posedge clk); #1;
            chk_idle("held reset");
            rst_n = 1'b1;
            mute  = 1'b0;
            return;
         end
         if (k == abort_at) begin
`ifdef BEEP_ABORT_EN
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            req_valid = 1'b0;
            chk_idle($sformatf("abort k=%0d", k));
            req_valid = 1'b1;
            abort = 1'b1;
            @(posedge clk); #1;
            chk("abort blocks accept busy", busy, 1'b0);
            req_valid = 1'b0;
            abort = 1'b0;
            mute  = 1'b0;
            return;
`endif
         end
         mute = 1'(mute_tab[k + 1]);
         @(posedge clk); #1;
      end
      chk_idle("end of request");
      mute = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      #3;
      chk_idle("in reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         chk_idle($sformatf("idle c=%0d", i));
         @(posedge clk); #1;
      end
      run_req(1'b0, 3'd1, 0, -1, -1, 1'b0);
      run_req(1'b0, 3'd3, 0, -1, -1, 1'b0);
      run_req(1'b0, 3'd0, 0, -1, -1, 1'b0);
      run_req(1'b1, 3'd5, 0, -1, -1, 1'b0);
      run_req(1'b0, 3'd3, 1, -1, -1, 1'b0);
      run_req(1'b0, 3'd7, 0, -1, -1, 1'b0);
      // Held request is taken on the first idle cycle after the previous one.
      run_req(1'b0, 3'd2, 0, -1, -1, 1'b1);
      run_req(1'b1, 3'd0, 0, -1, -1, 1'b0);
      run_req(1'b0, 3'd3, 0, 25, -1, 1'b0);
      run_req(1'b0, 3'd3, 0, 9, -1, 1'b0);
      run_req(1'b0, 3'd2, 0, -1, -1, 1'b0);
`ifdef BEEP_ABORT_EN
      run_req(1'b0, 3'd3, 0, -1, 25, 1'b0);
      run_req(1'b0, 3'd1, 0, -1, -1, 1'b0);
`endif
      for (int r = 0; r < 6; r++)
         run_req(1'($urandom), 3'($urandom), 2, -1, -1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
